sipo_deserializer: RTL and testbench

Serial-to-parallel receiver for the shift-register family: collects a framed, LSB-first bit stream, as produced by the 4-bit PISO transmitter, into a WIDTH-bit word. It presents each completed word on a valid/ready output port. It sits at the receiving end of the serial link and feeds a parallel consumer that may stall. Frame alignment is restored with a sync strobe, and lost words are flagged by a sticky overrun bit.

---
 rtl/sipo_deserializer_if.sv | 25 ++
 rtl/sipo_deserializer.sv | 83 ++++++++
 tb/tb_sipo_deserializer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out link bundle for sipo_deserializer.
// master: stream source + word consumer; slave: the deserializer.
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic             sync;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic             overrun;
    logic             clear_ovr;

    modport master (
        output sin, sin_valid, sync, pout_ready, clear_ovr,
        input  pout, pout_valid, busy, overrun
    );

    modport slave (
        input  sin, sin_valid, sync, pout_ready, clear_ovr,
        output pout, pout_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// LSB-first framed serial receiver; presents WIDTH-bit words on valid/ready.
// Ports: clk, reset_n (async low), bus (slave: sin/sin_valid/sync in, pout/pout_valid/busy/overrun out).
module sipo_deserializer #(
    parameter int WIDTH = 4
) (
    input logic                clk,
    input logic                reset_n,
    sipo_deserializer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] pout_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             pv_q;
    logic             ovr_q;
    logic             last_bit;
    logic             done;
    logic             ovr_ev;

    generate
        if (WIDTH == 1) begin : g_w1
            assign word = bus.sin;
        end else begin : g_wn
            assign word = {bus.sin, sh[WIDTH-1:1]};
        end
    endgenerate

    // sync forces the captured bit to be bit 0 of a fresh frame.
    always_comb begin
        last_bit = 1'b0;
        cnt_nxt  = cnt;
        if (WIDTH == 1) begin
            last_bit = 1'b1;
            cnt_nxt  = '0;
        end else if (bus.sync) begin
            cnt_nxt  = CW'(1);
        end else if (cnt == LAST) begin
            last_bit = 1'b1;
            cnt_nxt  = '0;
        end else begin
            cnt_nxt  = cnt + CW'(1);
        end
    end

    assign done   = bus.sin_valid & last_bit;
    assign ovr_ev = done & pv_q & ~bus.pout_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh     <= '0;
            cnt    <= '0;
            pout_q <= '0;
            pv_q   <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (bus.sin_valid) begin
                sh  <= word;
                cnt <= cnt_nxt;
            end
            // accept and reload may happen on the same edge
            if (done && (!pv_q || bus.pout_ready)) begin
                pout_q <= word;
                pv_q   <= 1'b1;
            end else if (!done && pv_q && bus.pout_ready) begin
                pv_q   <= 1'b0;
            end
            if (ovr_ev) begin
                ovr_q <= 1'b1;
            end else if (bus.clear_ovr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign bus.pout       = pout_q;
    assign bus.pout_valid = pv_q;
    assign bus.busy       = (cnt != '0);
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer with a frame-level reference model.
// Model builds words from a bit queue; outputs compared every cycle.
module tb_sipo_deserializer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;
    bit   chk_en = 1'b0;

    sipo_deserializer_if #(.WIDTH(W)) bus ();

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    bit         m_bits[$];
    logic [W-1:0] m_pout = '0;
    logic       m_pv = 1'b0;
    logic       m_ovr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pout = '0;
        m_pv   = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_edge(input logic b, input logic sv,
                              input logic sy, input logic rdy,
                              input logic clr);
        bit           done;
        bit           ev;
        logic [W-1:0] w;
        done = 0;
        ev   = 0;
        w    = '0;
        if (sv) begin
            if (sy) m_bits.delete();
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) w[i] = m_bits[i];
                m_bits.delete();
                done = 1;
            end
        end
        if (done) begin
            if (!m_pv || rdy) begin
                m_pout = w;
                m_pv   = 1'b1;
            end else begin
                ev = 1;
            end
        end else if (m_pv && rdy) begin
            m_pv = 1'b0;
        end
        if (ev) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    // drive, clock, update model; returns 1 time unit after the edge
    task automatic step(input logic b, input logic sv, input logic sy,
                        input logic rdy, input logic clr);
        bus.sin        = b;
        bus.sin_valid  = sv;
        bus.sync       = sy;
        bus.pout_ready = rdy;
        bus.clear_ovr  = clr;
        @(posedge clk);
        model_edge(b, sv, sy, rdy, clr);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic sy,
                             input logic rdy, input logic rdy_last,
                             input bit gap);
        for (int i = 0; i < W; i++) begin
            step(w[i], 1'b1, sy && (i == 0),
                 (i == W - 1) ? rdy_last : rdy, 1'b0);
            if (gap && i != W - 1) idle(rdy);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pout", 32'(bus.pout), 32'(m_pout));
            chk("pout_valid", 32'(bus.pout_valid), 32'(m_pv));
            chk("busy", 32'(bus.busy), 32'(m_bits.size() != 0));
            chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        end
    end

    initial begin
        logic [15:0] pat;
        bus.sin        = 1'b0;
        bus.sin_valid  = 1'b0;
        bus.sync       = 1'b0;
        bus.pout_ready = 1'b0;
        bus.clear_ovr  = 1'b0;
        #1;
        chk("rst_pout", 32'(bus.pout), 32'h0);
        chk("rst_pv", 32'(bus.pout_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ovr", 32'(bus.overrun), 32'h0);
        #12;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // basic word 1,0,1,1 -> 0xD
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("basic_busy1", 32'(bus.busy), 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("basic_busy2", 32'(bus.busy), 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("basic_busy3", 32'(bus.busy), 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("basic_pout", 32'(bus.pout), 32'hD);
        chk("basic_pv", 32'(bus.pout_valid), 32'h1);
        chk("basic_busy4", 32'(bus.busy), 32'h0);
        idle(1'b1);
        chk("basic_pv_pulse", 32'(bus.pout_valid), 32'h0);

        // gapped words 0xA, 0x5
        send_word(4'hA, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("gap_A", 32'(bus.pout), 32'hA);
        chk("gap_A_pv", 32'(bus.pout_valid), 32'h1);
        idle(1'b1);
        send_word(4'h5, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("gap_5", 32'(bus.pout), 32'h5);
        chk("gap_ovr", 32'(bus.overrun), 32'h0);
        idle(1'b1);

        // resync mid-frame
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("resync_busy", 32'(bus.busy), 32'h1);
        send_word(4'h4, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("resync_pout", 32'(bus.pout), 32'h4);
        chk("resync_busy0", 32'(bus.busy), 32'h0);
        idle(1'b1);

        // stall and overrun
        send_word(4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_pout", 32'(bus.pout), 32'h3);
        chk("stall_ovr", 32'(bus.overrun), 32'h1);
        idle(1'b1);
        chk("stall_acc_pv", 32'(bus.pout_valid), 32'h0);
        chk("stall_acc_pout", 32'(bus.pout), 32'h3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stall_clr", 32'(bus.overrun), 32'h0);

        // accept and complete on the same edge
        send_word(4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sim_9", 32'(bus.pout), 32'h9);
        send_word(4'h6, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sim_6", 32'(bus.pout), 32'h6);
        chk("sim_pv", 32'(bus.pout_valid), 32'h1);
        chk("sim_ovr", 32'(bus.overrun), 32'h0);
        idle(1'b1);

        // async reset mid-frame
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_pout", 32'(bus.pout), 32'h0);
        chk("arst_pv", 32'(bus.pout_valid), 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        chk("arst_ovr", 32'(bus.overrun), 32'h0);
        reset_n = 1'b1;
        send_word(4'hE, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("arst_E", 32'(bus.pout), 32'hE);
        chk("arst_E_pv", 32'(bus.pout_valid), 32'h1);

        // sustained free-running stream, no sync
        pat = 16'hB4E1;
        for (int i = 0; i < 16; i++) begin
            step(pat[i], 1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("stream_last", 32'(bus.pout), 32'hB);
        idle(1'b1);
        idle(1'b1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
